// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the R-type issue sequencer: ALU op codes, funct codes,
// instruction field positions and FSM state encoding.
package alu_op_sequencer_pkg;

  localparam int ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'd1;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'd2;
  localparam logic [ALU_OP_W-1:0] ALU_INC = 3'd3;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 3'd7;

  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_INC  = 6'h3F;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLLV = 6'h04;

  localparam logic [5:0] OP_RTYPE = 6'h00;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_e;

  // Arithmetic ops whose overflow can trap the write-back.
  function automatic logic is_ovf_op(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_INC) || (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_funct_decoder.sv
// Combinational R-type decoder: maps op/funct to a 3-bit ALU op plus a legal flag.
module alu_op_sequencer_funct_decoder
  import alu_op_sequencer_pkg::*;
(
  input  logic [5:0]          i_op,
  input  logic [5:0]          i_funct,
  output logic [ALU_OP_W-1:0] o_alu_op,
  output logic                o_legal
);

  logic w_funct_ok;

  always_comb begin
    o_alu_op   = ALU_AND;
    w_funct_ok = 1'b1;
    case (i_funct)
      FUNCT_AND:  o_alu_op = ALU_AND;
      FUNCT_OR:   o_alu_op = ALU_OR;
      FUNCT_XOR:  o_alu_op = ALU_XOR;
      FUNCT_INC:  o_alu_op = ALU_INC;
      FUNCT_ADD:  o_alu_op = ALU_ADD;
      FUNCT_SUB:  o_alu_op = ALU_SUB;
      FUNCT_SLT:  o_alu_op = ALU_SLT;
      FUNCT_SLLV: o_alu_op = ALU_SLL;
      default:    w_funct_ok = 1'b0;
    endcase
  end

  assign o_legal = (i_op == OP_RTYPE) && w_funct_ok;

endmodule

// File: rtl/alu_op_sequencer.sv
// Four-state issue sequencer (IDLE/DECODE/EXEC/WB) driving register-file
// addresses, ALU op and the write strobe; one instruction per four cycles.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter bit TRAP_ON_OF = 1'b1
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic [31:0]         instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic                ZF,
  input  logic                OF,
  output logic [4:0]          R_Addr_A,
  output logic [4:0]          R_Addr_B,
  output logic [4:0]          W_Addr,
  output logic [ALU_OP_W-1:0] ALU_OP,
  output logic                Write_Reg,
  output logic                zf_q,
  output logic                of_q,
  output logic                illegal,
  output logic                ovf_trap,
  output logic [CNT_W-1:0]    retired
);

  state_e              r_state;
  logic [5:0]          r_op;
  logic [5:0]          r_funct;
  logic [4:0]          r_rs;
  logic [4:0]          r_rt;
  logic [4:0]          r_rd;
  logic                r_ovf_sup;

  logic [ALU_OP_W-1:0] w_alu_op;
  logic                w_legal;
  logic                w_ovf_hit;
  logic                w_unused_shamt;

  // The shift-amount field has no meaning for this op set.
  assign w_unused_shamt = ^instr[SHAMT_MSB:SHAMT_LSB];

  alu_op_sequencer_funct_decoder u_funct_decoder (
    .i_op     (r_op),
    .i_funct  (r_funct),
    .o_alu_op (w_alu_op),
    .o_legal  (w_legal)
  );

  // OF is sampled at the end of EXEC so the strobe can be decided before WB.
  assign w_ovf_hit = TRAP_ON_OF && is_ovf_op(ALU_OP) && OF;

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_op        <= '0;
      r_funct     <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_ovf_sup   <= 1'b0;
      instr_ready <= 1'b1;
      R_Addr_A    <= '0;
      R_Addr_B    <= '0;
      W_Addr      <= '0;
      ALU_OP      <= '0;
      Write_Reg   <= 1'b0;
      zf_q        <= 1'b0;
      of_q        <= 1'b0;
      illegal     <= 1'b0;
      ovf_trap    <= 1'b0;
      retired     <= '0;
    end else begin
      Write_Reg <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (instr_valid && instr_ready) begin
            r_op        <= instr[OP_MSB:OP_LSB];
            r_rs        <= instr[RS_MSB:RS_LSB];
            r_rt        <= instr[RT_MSB:RT_LSB];
            r_rd        <= instr[RD_MSB:RD_LSB];
            r_funct     <= instr[FUNCT_MSB:FUNCT_LSB];
            instr_ready <= 1'b0;
            r_state     <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          R_Addr_A <= r_rs;
          R_Addr_B <= r_rt;
          W_Addr   <= r_rd;
          ALU_OP   <= w_alu_op;
          if (w_legal) begin
            r_state <= ST_EXEC;
          end else begin
            illegal     <= 1'b1;
            instr_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          // Writes to r0 are dropped so it always reads as zero.
          Write_Reg <= !w_ovf_hit && (W_Addr != 5'd0);
          r_ovf_sup <= w_ovf_hit;
          r_state   <= ST_WB;
        end
        ST_WB: begin
          zf_q <= ZF;
          of_q <= OF;
          if (r_ovf_sup) begin
            ovf_trap <= 1'b1;
          end else begin
            retired <= retired + 1'b1;
          end
          instr_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          instr_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: vector table, reset/back-to-back/wrap sequences and a
// randomized run checked against a list-lookup reference model.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        Reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic        ZF;
  logic        OF;

  logic        instr_ready;
  logic [4:0]  R_Addr_A, R_Addr_B, W_Addr;
  logic [2:0]  ALU_OP;
  logic        Write_Reg, zf_q, of_q, illegal, ovf_trap;
  logic [15:0] retired;

  logic        r3_ready;
  logic [4:0]  r3_a, r3_b, r3_w;
  logic [2:0]  r3_op;
  logic        r3_wr, r3_zf, r3_of, r3_ill, r3_trap;
  logic [2:0]  retired3;

  alu_op_sequencer #(.CNT_W(16), .TRAP_ON_OF(1'b1)) dut (
    .clk(clk), .Reset(Reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .ZF(ZF), .OF(OF),
    .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .W_Addr(W_Addr), .ALU_OP(ALU_OP),
    .Write_Reg(Write_Reg), .zf_q(zf_q), .of_q(of_q), .illegal(illegal),
    .ovf_trap(ovf_trap), .retired(retired)
  );

  alu_op_sequencer #(.CNT_W(3), .TRAP_ON_OF(1'b1)) dut3 (
    .clk(clk), .Reset(Reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(r3_ready), .ZF(ZF), .OF(OF),
    .R_Addr_A(r3_a), .R_Addr_B(r3_b), .W_Addr(r3_w), .ALU_OP(r3_op),
    .Write_Reg(r3_wr), .zf_q(r3_zf), .of_q(r3_of), .illegal(r3_ill),
    .ovf_trap(r3_trap), .retired(retired3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int exp_ret;
  bit exp_ill, exp_trap;

  // ALU op code is the position of the funct in this list.
  int codes[8] = '{'h24, 'h25, 'h26, 'h3F, 'h20, 'h22, 'h2A, 'h04};

  typedef struct {
    logic [31:0] word;
    logic        zf;
    logic        of;
    logic [2:0]  alu;
    logic        legal;
    logic        write;
  } vec_t;

  vec_t tbl[14];

  function automatic int ref_alu(input logic [5:0] f);
    for (int i = 0; i < 8; i++)
      if (codes[i] == int'(f)) return i;
    return -1;
  endfunction

  function automatic logic [31:0] mk(input int op, input int rs, input int rt,
                                     input int rd, input int f);
    logic [31:0] w;
    w = 32'(op) << 26;
    w = w | ((32'(rs) & 32'h1F) << 21);
    w = w | ((32'(rt) & 32'h1F) << 16);
    w = w | ((32'(rd) & 32'h1F) << 11);
    w = w | (32'(f) & 32'h3F);
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    exp_ret  = 0;
    exp_ill  = 1'b0;
    exp_trap = 1'b0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ready"}, 32'(instr_ready), 1);
    chk({nm, "_wr"},    32'(Write_Reg), 0);
    chk({nm, "_addr"},  {17'd0, R_Addr_A, R_Addr_B, W_Addr}, 0);
    chk({nm, "_aluop"}, 32'(ALU_OP), 0);
    chk({nm, "_flags"}, {28'd0, zf_q, of_q, illegal, ovf_trap}, 0);
    chk({nm, "_ret"},   32'(retired), 0);
    chk({nm, "_ret3"},  32'(retired3), 0);
  endtask

  task automatic do_reset;
    Reset = 1'b1;
    instr_valid = 1'b0;
    tick;
    Reset = 1'b0;
    model_reset;
  endtask

  // Issue one instruction and follow it through the four-cycle sequence.
  task automatic run_instr(input string nm, input logic [31:0] w, input logic z,
                           input logic o, input logic [2:0] ea, input logic el,
                           input logic ew);
    int  n;
    bit  trap;
    trap = el && o && (ea == 3'd3 || ea == 3'd4 || ea == 3'd5);
    instr = w; instr_valid = 1'b1; ZF = z; OF = o;
    n = 0;
    while (!instr_ready && n < 10) begin tick; n++; end
    if (!instr_ready) chk({nm, "_ready_timeout"}, 32'(instr_ready), 1);
    tick;                                   // accept edge
    instr_valid = 1'b0;
    instr = $urandom;                       // must be ignored while busy
    chk({nm, "_busy"}, 32'(instr_ready), 0);
    tick;                                   // decode edge
    chk({nm, "_wr_dec"}, 32'(Write_Reg), 0);
    if (!el) begin
      exp_ill = 1'b1;
      chk({nm, "_illegal"}, 32'(illegal), 1);
      chk({nm, "_ready_ill"}, 32'(instr_ready), 1);
      chk({nm, "_ret_ill"}, 32'(retired), 32'(exp_ret));
      $display("instr %s word=0x%08h illegal ret=%0d", nm, w, retired);
      return;
    end
    chk({nm, "_raddr_a"}, 32'(R_Addr_A), 32'(w[25:21]));
    chk({nm, "_raddr_b"}, 32'(R_Addr_B), 32'(w[20:16]));
    chk({nm, "_waddr"},   32'(W_Addr),   32'(w[15:11]));
    chk({nm, "_aluop"},   32'(ALU_OP),   32'(ea));
    tick;                                   // exec edge: now in WB
    chk({nm, "_wr_wb"}, 32'(Write_Reg), 32'(ew));
    chk({nm, "_aluop_hold"}, 32'(ALU_OP), 32'(ea));
    tick;                                   // write-back edge
    if (trap) exp_trap = 1'b1;
    else exp_ret++;
    chk({nm, "_wr_after"}, 32'(Write_Reg), 0);
    chk({nm, "_ready_after"}, 32'(instr_ready), 1);
    chk({nm, "_zfof"}, {30'd0, zf_q, of_q}, {30'd0, z, o});
    chk({nm, "_sticky"}, {30'd0, illegal, ovf_trap}, {30'd0, exp_ill, exp_trap});
    chk({nm, "_ret"}, 32'(retired), 32'(exp_ret));
    chk({nm, "_ret3"}, 32'(retired3), 32'(exp_ret % 8));
    $display("instr %s word=0x%08h alu=%0d wr=%0b ret=%0d trap=%0b",
             nm, w, ALU_OP, ew, retired, ovf_trap);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          last_acc;
    int          n;
    logic [31:0] w;
    logic [5:0]  f;
    int          op, a;
    bit          el, ew, o, z;

    tbl[0]  = '{32'h00430820, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1}; // add rd1 rs2 rt3
    tbl[1]  = '{32'h00000022, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0}; // sub rd0
    tbl[2]  = '{32'h20000000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0}; // op 0x08
    tbl[3]  = '{32'h00430830, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0}; // funct 0x30
    tbl[4]  = '{32'h00222820, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0}; // add rd5 OF
    tbl[5]  = '{32'h00222826, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1}; // xor rd5 OF
    tbl[6]  = '{32'h0022283F, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0}; // inc OF
    tbl[7]  = '{32'h00222822, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0}; // sub OF
    tbl[8]  = '{32'h0022282A, 1'b0, 1'b1, 3'd6, 1'b1, 1'b1}; // slt OF
    tbl[9]  = '{32'h00222804, 1'b1, 1'b0, 3'd7, 1'b1, 1'b1}; // sllv
    tbl[10] = '{32'h00222824, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1}; // and
    tbl[11] = '{32'h00222825, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1}; // or
    tbl[12] = '{32'h00222821, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0}; // funct 0x21
    tbl[13] = '{32'h00220020, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0}; // add rd0 OF

    Reset = 1'b1; instr = '0; instr_valid = 1'b0; ZF = 1'b0; OF = 1'b0;
    tick; tick;
    Reset = 1'b0;
    model_reset;
    chk_reset_vals("reset");

    // Valid held while busy must be ignored: no accept effect beyond the first.
    for (int i = 0; i < 14; i++)
      run_instr($sformatf("tbl%0d", i), tbl[i].word, tbl[i].zf, tbl[i].of,
                tbl[i].alu, tbl[i].legal, tbl[i].write);

    // Reset while in EXEC: the strobe must never appear.
    do_reset;
    instr = mk(0, 2, 3, 1, 'h20); instr_valid = 1'b1; ZF = 1'b0; OF = 1'b0;
    tick;
    instr_valid = 1'b0;
    tick;
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    chk_reset_vals("rst_exec");
    tick;
    chk("rst_exec_nowr1", 32'(Write_Reg), 0);
    tick;
    chk("rst_exec_nowr2", 32'(Write_Reg), 0);
    $display("seq reset_in_exec wr=%0b ready=%0b", Write_Reg, instr_ready);

    // Build up sticky/counter state, then reset while in WB.
    run_instr("pre_trap", 32'h00222820, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0);
    run_instr("pre_xor",  32'h00222826, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1);
    run_instr("pre_ill",  32'h20000000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    instr = mk(0, 4, 5, 6, 'h26); instr_valid = 1'b1; ZF = 1'b1; OF = 1'b1;
    tick;
    instr_valid = 1'b0;
    tick; tick;
    chk("rst_wb_in_wb", 32'(Write_Reg), 1);
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    model_reset;
    chk_reset_vals("rst_wb");
    $display("seq reset_in_wb ret=%0d sticky=%0b%0b", retired, illegal, ovf_trap);

    // Back-to-back with valid held high; 3-bit counter wraps on the 8th.
    do_reset;
    instr_valid = 1'b1; ZF = 1'b0; OF = 1'b0;
    last_acc = 0;
    for (int k = 0; k < 8; k++) begin
      instr = mk(0, k, k + 8, k + 1, codes[k]);
      n = 0;
      while (!instr_ready && n < 8) begin tick; n++; end
      if (!instr_ready) chk("b2b_ready_timeout", 32'(instr_ready), 1);
      if (k == 7) chk("b2b_ret3_pre", 32'(retired3), 7);
      tick;
      if (k > 0) chk($sformatf("b2b_gap%0d", k), 32'(cyc - last_acc), 4);
      last_acc = cyc;
      if (k == 7) instr_valid = 1'b0;
      tick;
      chk($sformatf("b2b_aluop%0d", k), 32'(ALU_OP), 32'(k));
      $display("b2b k=%0d alu=%0d cyc=%0d", k, ALU_OP, cyc);
    end
    n = 0;
    while (!instr_ready && n < 8) begin tick; n++; end
    exp_ret = 8;
    chk("b2b_ret", 32'(retired), 8);
    chk("b2b_ret3_wrap", 32'(retired3), 0);

    // Randomized run against the reference model.
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 63)) : 0;
      f  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'(codes[$urandom_range(0, 7)]);
      w  = mk(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 31)), int'(f));
      z  = 1'($urandom);
      o  = 1'($urandom);
      a  = ref_alu(f);
      el = (op == 0) && (a >= 0);
      if (a < 0) a = 0;
      ew = el && (w[15:11] != 5'd0) && !(o && (a >= 3 && a <= 5));
      run_instr($sformatf("rnd%0d", i), w, z, o, 3'(a), el, ew);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
